// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared mode/field encodings and defaults for the digital clock
package clock_pkg;

  typedef enum logic [2:0] {
    MODE_RUN       = 3'b000,
    MODE_SET_TIME  = 3'b001,
    MODE_SET_ALARM = 3'b010
  } mode_e;

  localparam logic FIELD_HR  = 1'b0;
  localparam logic FIELD_MIN = 1'b1;

  localparam int TIMEOUT_S_DEFAULT   = 30;
  localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// rtl/clock_mode_ctrl_if.sv - button/tick inputs and mode/strobe outputs of the UI controller
interface clock_mode_ctrl_if;

  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_sel;
  logic       btn_inc;
  logic [2:0] mode;
  logic       field;
  logic       time_run;
  logic       inc_time_hr;
  logic       inc_time_min;
  logic       inc_alarm_hr;
  logic       inc_alarm_min;
  logic       clr_seconds;
  logic       alarm_arm;
  logic       blink;

  // Board side: supplies tick and buttons, consumes mode and strobes
  modport master (
    output tick_1hz, btn_mode, btn_sel, btn_inc,
    input  mode, field, time_run, inc_time_hr, inc_time_min,
    input  inc_alarm_hr, inc_alarm_min, clr_seconds, alarm_arm, blink
  );

  // Controller side
  modport slave (
    input  tick_1hz, btn_mode, btn_sel, btn_inc,
    output mode, field, time_run, inc_time_hr, inc_time_min,
    output inc_alarm_hr, inc_alarm_min, clr_seconds, alarm_arm, blink
  );

endinterface

// File: rtl/clock_mode_ctrl_btn_edge.sv
// rtl/clock_mode_ctrl_btn_edge.sv - button synchronizer with registered rising-edge press pulse
module btn_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] vld_q, vld_d;
  logic                   prev_q, prev_d;
  logic                   armed_q, armed_d;
  logic                   press_q, press_d;
  logic                   level;

  // The chain is only trusted once it has refilled after reset (vld); a press
  // is accepted only after a released level has been seen, so a button held
  // through reset needs a release before it can fire.
  always_comb begin
    level   = sync_q[SYNC_STAGES-1];
    sync_d  = {sync_q[SYNC_STAGES-2:0], btn_in};
    vld_d   = {vld_q[SYNC_STAGES-2:0], 1'b1};
    prev_d  = level;
    armed_d = armed_q | (vld_q[SYNC_STAGES-1] & ~level);
    press_d = level & ~prev_q & armed_q;
  end

  // Register chain, edge history and the press pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      vld_q   <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      vld_q   <= vld_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - mode FSM, field select, increment strobes, blink and edit timeout
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S   = TIMEOUT_S_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  clock_mode_ctrl_if.slave   bus
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_S - 1);

  logic p_mode, p_sel, p_inc;

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge_mode (
    .clk(clk), .reset_n(reset_n), .btn_in(bus.btn_mode), .press(p_mode));
  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sel (
    .clk(clk), .reset_n(reset_n), .btn_in(bus.btn_sel), .press(p_sel));
  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge_inc (
    .clk(clk), .reset_n(reset_n), .btn_in(bus.btn_inc), .press(p_inc));

  mode_e      mode_q, mode_d;
  logic       field_q, field_d;
  logic       time_run_q, time_run_d;
  logic       arm_q, arm_d;
  logic       blink_q, blink_d;
  logic [7:0] cnt_q, cnt_d;
  logic       thr_q, thr_d, tmin_q, tmin_d;
  logic       ahr_q, ahr_d, amin_q, amin_d;
  logic       clr_q, clr_d;
  logic       edit_press;

  // Next-state: mode press beats sel beats inc; a press beats a timeout tick
  always_comb begin
    mode_d     = mode_q;
    field_d    = field_q;
    arm_d      = arm_q;
    blink_d    = blink_q;
    cnt_d      = cnt_q;
    thr_d      = 1'b0;
    tmin_d     = 1'b0;
    ahr_d      = 1'b0;
    amin_d     = 1'b0;
    clr_d      = 1'b0;
    edit_press = p_sel | p_inc;

    case (mode_q)
      MODE_RUN: begin
        cnt_d   = 8'd0;
        blink_d = 1'b0;
        if (p_mode) begin
          mode_d = MODE_SET_TIME;
        end else if (!p_sel && p_inc) begin
          arm_d = ~arm_q;
        end
      end
      MODE_SET_TIME, MODE_SET_ALARM: begin
        if (p_mode) begin
          mode_d = (mode_q == MODE_SET_TIME) ? MODE_SET_ALARM : MODE_RUN;
          clr_d  = (mode_q == MODE_SET_TIME);
        end else if (edit_press) begin
          cnt_d = 8'd0;
          if (bus.tick_1hz) blink_d = ~blink_q;
          if (p_sel) begin
            field_d = ~field_q;
          end else if (mode_q == MODE_SET_TIME) begin
            thr_d  = (field_q == FIELD_HR);
            tmin_d = (field_q == FIELD_MIN);
          end else begin
            ahr_d  = (field_q == FIELD_HR);
            amin_d = (field_q == FIELD_MIN);
          end
        end else if (bus.tick_1hz) begin
          if (cnt_q == TIMEOUT_LAST) begin
            mode_d = MODE_RUN;
            clr_d  = (mode_q == MODE_SET_TIME);
          end else begin
            cnt_d   = 8'(cnt_q + 8'd1);
            blink_d = ~blink_q;
          end
        end
      end
      default: mode_d = MODE_RUN;
    endcase

    // Every mode change restarts field, blink phase and timeout
    if (mode_d != mode_q) begin
      field_d = FIELD_HR;
      blink_d = 1'b0;
      cnt_d   = 8'd0;
    end
    time_run_d = (mode_d != MODE_SET_TIME);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= MODE_RUN;
      field_q    <= FIELD_HR;
      time_run_q <= 1'b1;
      arm_q      <= 1'b0;
      blink_q    <= 1'b0;
      cnt_q      <= 8'd0;
      thr_q      <= 1'b0;
      tmin_q     <= 1'b0;
      ahr_q      <= 1'b0;
      amin_q     <= 1'b0;
      clr_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      field_q    <= field_d;
      time_run_q <= time_run_d;
      arm_q      <= arm_d;
      blink_q    <= blink_d;
      cnt_q      <= cnt_d;
      thr_q      <= thr_d;
      tmin_q     <= tmin_d;
      ahr_q      <= ahr_d;
      amin_q     <= amin_d;
      clr_q      <= clr_d;
    end
  end

  assign bus.mode          = mode_q;
  assign bus.field         = field_q;
  assign bus.time_run      = time_run_q;
  assign bus.alarm_arm     = arm_q;
  assign bus.blink         = blink_q;
  assign bus.inc_time_hr   = thr_q;
  assign bus.inc_time_min  = tmin_q;
  assign bus.inc_alarm_hr  = ahr_q;
  assign bus.inc_alarm_min = amin_q;
  assign bus.clr_seconds   = clr_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb/tb_clock_mode_ctrl.sv - directed plus random check of clock_mode_ctrl against a reference model
module tb_clock_mode_ctrl;

  localparam int TO = 3;

  logic clk;
  logic reset_n;

  clock_mode_ctrl_if bus ();

  clock_mode_ctrl #(.TIMEOUT_S(TO), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state: mode 0 RUN, 1 SET_TIME, 2 SET_ALARM
  int em, ecnt;
  bit ef, ea, eb, etr;
  bit e_thr, e_tmin, e_ahr, e_amin, e_clr;
  bit hm[$], hs[$], hi[$];

  // observed strobe totals for directed windows
  int c_thr, c_tmin, c_ahr, c_amin, c_clr;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // A press takes effect at edge e when the level sampled at e-3 is high and
  // at e-4 low, and that low sample was taken after reset release.
  function automatic bit rose(input bit q[$]);
    if (q.size() < 5) return 1'b0;
    return q[q.size()-4] && !q[q.size()-5];
  endfunction

  task automatic model_reset();
    em = 0; ecnt = 0; ef = 0; ea = 0; eb = 0; etr = 1;
    e_thr = 0; e_tmin = 0; e_ahr = 0; e_amin = 0; e_clr = 0;
    hm.delete(); hs.delete(); hi.delete();
  endtask

  task automatic model_step();
    bit pm, ps, pi, tk;
    int old;
    tk = bus.tick_1hz;
    hm.push_back(bus.btn_mode); if (hm.size() > 5) void'(hm.pop_front());
    hs.push_back(bus.btn_sel);  if (hs.size() > 5) void'(hs.pop_front());
    hi.push_back(bus.btn_inc);  if (hi.size() > 5) void'(hi.pop_front());
    pm = rose(hm);
    ps = rose(hs) && !pm;
    pi = rose(hi) && !pm && !ps;
    e_thr = 0; e_tmin = 0; e_ahr = 0; e_amin = 0; e_clr = 0;
    old = em;
    if (old == 0) begin
      if (pm) em = 1;
      else if (pi) ea = !ea;
    end else if (pm) begin
      em = (old + 1) % 3;
      e_clr = (old == 1);
    end else if (ps || pi) begin
      ecnt = 0;
      if (tk) eb = !eb;
      if (ps) ef = !ef;
      else if (old == 1) begin e_thr = !ef; e_tmin = ef; end
      else begin e_ahr = !ef; e_amin = ef; end
    end else if (tk) begin
      ecnt++;
      if (ecnt == TO) begin em = 0; e_clr = (old == 1); end
      else eb = !eb;
    end
    if (em != old) begin ef = 0; eb = 0; ecnt = 0; end
    etr = (em != 1);
  endtask

  task automatic compare_all();
    check_eq("mode", bus.mode, em);
    check_eq("field", bus.field, ef);
    check_eq("time_run", bus.time_run, etr);
    check_eq("alarm_arm", bus.alarm_arm, ea);
    check_eq("blink", bus.blink, eb);
    check_eq("inc_time_hr", bus.inc_time_hr, e_thr);
    check_eq("inc_time_min", bus.inc_time_min, e_tmin);
    check_eq("inc_alarm_hr", bus.inc_alarm_hr, e_ahr);
    check_eq("inc_alarm_min", bus.inc_alarm_min, e_amin);
    check_eq("clr_seconds", bus.clr_seconds, e_clr);
    c_thr  += int'(bus.inc_time_hr);
    c_tmin += int'(bus.inc_time_min);
    c_ahr  += int'(bus.inc_alarm_hr);
    c_amin += int'(bus.inc_alarm_min);
    c_clr  += int'(bus.clr_seconds);
  endtask

  // Called at a negedge: drive inputs, advance one clock, compare at next negedge
  task automatic step(input bit tk, input bit bm, input bit bs, input bit bi);
    bus.tick_1hz = tk;
    bus.btn_mode = bm;
    bus.btn_sel  = bs;
    bus.btn_inc  = bi;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  // which: 0 mode, 1 sel, 2 inc; two-cycle press then settle
  task automatic press(input int which);
    for (int i = 0; i < 2; i++) step(0, which == 0, which == 1, which == 2);
    idle(6);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    bus.tick_1hz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compare_all();
    end
    reset_n = 1'b1;
  endtask

  task automatic clear_counts();
    c_thr = 0; c_tmin = 0; c_ahr = 0; c_amin = 0; c_clr = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.tick_1hz = 0; bus.btn_mode = 0; bus.btn_sel = 0; bus.btn_inc = 0;
    clear_counts();
    @(negedge clk);
    do_reset();
    idle(4);

    // mode cycle RUN -> SET_TIME -> SET_ALARM -> RUN
    clear_counts();
    press(0);
    check_eq("plan_mode_1", bus.mode, 1);
    check_eq("plan_time_run_edit", bus.time_run, 0);
    press(0);
    check_eq("plan_mode_2", bus.mode, 2);
    press(0);
    check_eq("plan_mode_0", bus.mode, 0);
    check_eq("plan_clr_count", c_clr, 1);

    // SET_TIME increments; long hold gives one pulse
    press(0);
    clear_counts();
    press(2);
    press(1);
    for (int i = 0; i < 100; i++) step(0, 0, 0, 1);
    idle(6);
    check_eq("plan_hr_pulses", c_thr, 1);
    check_eq("plan_min_pulses", c_tmin, 1);
    press(0);
    press(0);

    // alarm arm toggling in RUN
    clear_counts();
    press(2);
    check_eq("plan_arm_on", bus.alarm_arm, 1);
    press(2);
    check_eq("plan_arm_off", bus.alarm_arm, 0);
    check_eq("plan_run_strobes", c_thr + c_tmin + c_ahr + c_amin, 0);

    // simultaneous mode+inc in SET_ALARM
    press(0);
    press(0);
    clear_counts();
    for (int i = 0; i < 2; i++) step(0, 1, 0, 1);
    idle(6);
    check_eq("plan_simul_mode", bus.mode, 0);
    check_eq("plan_simul_strobes", c_ahr + c_amin, 0);

    // timeout from SET_TIME
    press(0);
    clear_counts();
    for (int i = 0; i < TO; i++) begin step(1, 0, 0, 0); idle(2); end
    check_eq("plan_timeout_mode", bus.mode, 0);
    check_eq("plan_timeout_clr", c_clr, 1);

    // sel press restarts the timeout
    press(0);
    step(1, 0, 0, 0); idle(2);
    step(1, 0, 0, 0); idle(2);
    press(1);
    step(1, 0, 0, 0); idle(2);
    check_eq("plan_no_timeout", bus.mode, 1);
    press(0);
    press(0);

    // button held through reset must not fire
    bus.btn_mode = 1'b1;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    check_eq("plan_held_reset", bus.mode, 0);
    idle(2);
    press(0);
    check_eq("plan_repress", bus.mode, 1);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      bit bm, bs, bi, tk;
      bm = bus.btn_mode ^ ($urandom_range(0, 5) == 0);
      bs = bus.btn_sel  ^ ($urandom_range(0, 5) == 0);
      bi = bus.btn_inc  ^ ($urandom_range(0, 5) == 0);
      tk = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 399) == 0) begin
        bus.btn_mode = bm; bus.btn_sel = bs; bus.btn_inc = bi;
        do_reset();
      end else begin
        step(tk, bm, bs, bi);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
